sipo_deframer: RTL and testbench

- Parametrised serial-in/parallel-out deframer for the UART receive path; successor to the fixed 8-bit receive shift register.
- Accumulates DATA_W sampled bits under a `shift` strobe from the receive bit-timing FSM, in either bit order.
- Counts bits itself and hands each completed word to the downstream consumer through a registered valid/ready holding stage.
- Flags overrun, and optionally parity error.

---
 rtl/uart_pkg.sv | 19 +
 rtl/sipo_hold_stage.sv | 58 +++++
 rtl/sipo_deframer.sv | 149 ++++++++++++++
 tb/tb_sipo_deframer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART receive-path definitions: deframer FSM states, default word
// width, bit-order selectors and a parity helper.
package uart_pkg;

   localparam int unsigned DATA_W_DEFAULT  = 8;
   localparam int unsigned LSB_FIRST_ORDER = 1;
   localparam int unsigned MSB_FIRST_ORDER = 0;

   typedef enum logic {
      ST_COLLECT = 1'b0,
      ST_PARITY  = 1'b1
   } deframer_state_t;

   // XOR-reduction of a word zero-extended to 16 bits (widest legal word).
   function automatic logic parity16(input logic [15:0] value);
      return ^value;
   endfunction

endpackage

// File: rtl/sipo_hold_stage.sv
// Single-entry valid/ready holding register with sticky overrun detection.
// A new offer is accepted when the stage is empty or being drained in the
// same cycle; otherwise it is dropped and overrun is raised.
module sipo_hold_stage #(
   parameter int unsigned W = 9
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         offer,
   input  logic [W-1:0] offer_data,
   input  logic         out_ready,
   input  logic         ovr_clr,
   output logic [W-1:0] out_data,
   output logic         out_valid,
   output logic         overrun
);

   logic accept;
   logic drop;

   // Decode whether the current offer is taken or lost.
   always_comb begin
      accept = 1'b0;
      drop   = 1'b0;
      if (offer) begin
         if (!out_valid || out_ready) begin
            accept = 1'b1;
         end else begin
            drop = 1'b1;
         end
      end else begin
         accept = 1'b0;
         drop   = 1'b0;
      end
   end

   // Holding register, valid flag and sticky overrun (set beats clear).
   always_ff @(posedge clk) begin
      if (rst) begin
         out_data  <= '0;
         out_valid <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (accept) begin
            out_data  <= offer_data;
            out_valid <= 1'b1;
         end else if (out_valid && out_ready && !offer) begin
            out_valid <= 1'b0;
         end
         if (drop) begin
            overrun <= 1'b1;
         end else if (ovr_clr) begin
            overrun <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/sipo_deframer.sv
// Serial-in/parallel-out deframer for the UART receive path.
// Collects DATA_W bits under the shift strobe in either bit order and hands
// each word to a valid/ready holding stage.
// Optional build macro PARITY_CHECK_EN: adds a trailing parity bit per frame
// (PARITY state) and reports parity_err alongside out_data; without it
// parity_err is always 0.
module sipo_deframer
   import uart_pkg::*;
#(
   parameter int unsigned DATA_W     = DATA_W_DEFAULT,
   parameter int unsigned LSB_FIRST  = LSB_FIRST_ORDER,
   parameter int unsigned PARITY_ODD = 0
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        frame_rst,
   input  logic                        shift,
   input  logic                        in,
   output logic [DATA_W-1:0]           out_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic                        overrun,
   input  logic                        ovr_clr,
   output logic                        parity_err,
   output logic                        busy,
   output logic [$clog2(DATA_W+1)-1:0] bit_cnt
);

   localparam int unsigned CNT_W = $clog2(DATA_W + 1);

   if (DATA_W < 5 || DATA_W > 16 || LSB_FIRST > 1 || PARITY_ODD > 1) begin : g_param_check
      $error("sipo_deframer: illegal parameter value");
   end

   logic [DATA_W-1:0] sreg;
   logic [DATA_W-1:0] shifted;
   logic              last_bit;
   deframer_state_t   state;
   logic              offer;
   logic [DATA_W:0]   offer_data;
   logic [DATA_W:0]   hold_data;

`ifdef PARITY_CHECK_EN
   logic [DATA_W-1:0] word;
   logic              parity_err_next;
`endif

   // Shift register contents including the bit sampled this cycle.
   always_comb begin
      if (LSB_FIRST == LSB_FIRST_ORDER) begin
         shifted = {in, sreg[DATA_W-1:1]};
      end else begin
         shifted = {sreg[DATA_W-2:0], in};
      end
   end

   assign last_bit = (bit_cnt == CNT_W'(DATA_W - 1));

`ifdef PARITY_CHECK_EN
   assign parity_err_next = parity16(16'(word)) ^ in ^ 1'(PARITY_ODD);

   // A word is offered once its parity bit has been sampled.
   always_comb begin
      offer      = 1'b0;
      offer_data = '0;
      if (!frame_rst && shift && (state == ST_PARITY)) begin
         offer      = 1'b1;
         offer_data = {parity_err_next, word};
      end else begin
         offer      = 1'b0;
         offer_data = '0;
      end
   end
`else
   // A word is offered on the edge that samples its final data bit.
   always_comb begin
      offer      = 1'b0;
      offer_data = '0;
      if (!frame_rst && shift && (state == ST_COLLECT) && last_bit) begin
         offer      = 1'b1;
         offer_data = {1'b0, shifted};
      end else begin
         offer      = 1'b0;
         offer_data = '0;
      end
   end
`endif

   // Bit collection FSM: shift register, bit counter and frame state.
   always_ff @(posedge clk) begin
      if (rst) begin
         sreg    <= '0;
         bit_cnt <= '0;
         state   <= ST_COLLECT;
`ifdef PARITY_CHECK_EN
         word    <= '0;
`endif
      end else if (frame_rst) begin
         sreg    <= '0;
         bit_cnt <= '0;
         state   <= ST_COLLECT;
      end else if (shift) begin
         case (state)
            ST_COLLECT: begin
               if (last_bit) begin
                  sreg    <= '0;
                  bit_cnt <= '0;
`ifdef PARITY_CHECK_EN
                  word    <= shifted;
                  state   <= ST_PARITY;
`else
                  state   <= ST_COLLECT;
`endif
               end else begin
                  sreg    <= shifted;
                  bit_cnt <= bit_cnt + CNT_W'(1);
               end
            end
            ST_PARITY: begin
               state <= ST_COLLECT;
            end
            default: begin
               state <= ST_COLLECT;
            end
         endcase
      end
   end

   sipo_hold_stage #(
      .W(DATA_W + 1)
   ) u_hold (
      .clk       (clk),
      .rst       (rst),
      .offer     (offer),
      .offer_data(offer_data),
      .out_ready (out_ready),
      .ovr_clr   (ovr_clr),
      .out_data  (hold_data),
      .out_valid (out_valid),
      .overrun   (overrun)
   );

   // The top hold bit carries the parity result; in the plain build it is
   // only ever loaded with 0.
   assign out_data   = hold_data[DATA_W-1:0];
   assign parity_err = hold_data[DATA_W];
   assign busy       = (bit_cnt != '0) || (state == ST_PARITY);

endmodule

// File: tb/tb_sipo_deframer.sv
// Directed bench for sipo_deframer: one LSB-first and one MSB-first instance
// driven by the same serial stream. Add +define+PARITY_CHECK_EN to exercise
// the parity build.
module tb_sipo_deframer;

   logic       clk = 1'b0;
   logic       rst, frame_rst, shift, in_bit, out_ready, ovr_clr;
   logic [7:0] l_data, m_data;
   logic       l_valid, m_valid, l_ovr, m_ovr, l_perr, m_perr, l_busy, m_busy;
   logic [3:0] l_cnt, m_cnt;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   sipo_deframer #(.DATA_W(8), .LSB_FIRST(1), .PARITY_ODD(0)) u_lsb (
      .clk(clk), .rst(rst), .frame_rst(frame_rst), .shift(shift), .in(in_bit),
      .out_data(l_data), .out_valid(l_valid), .out_ready(out_ready),
      .overrun(l_ovr), .ovr_clr(ovr_clr), .parity_err(l_perr),
      .busy(l_busy), .bit_cnt(l_cnt));

   sipo_deframer #(.DATA_W(8), .LSB_FIRST(0), .PARITY_ODD(0)) u_msb (
      .clk(clk), .rst(rst), .frame_rst(frame_rst), .shift(shift), .in(in_bit),
      .out_data(m_data), .out_valid(m_valid), .out_ready(out_ready),
      .overrun(m_ovr), .ovr_clr(ovr_clr), .parity_err(m_perr),
      .busy(m_busy), .bit_cnt(m_cnt));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Send a frame whose serial bit i is v[i]; parity bit follows in the parity
   // build. out_ready takes value rl for the final strobe and keeps it.
   task automatic send_frame(input logic [7:0] v, input logic pbit, input logic rl);
      int n;
      logic [8:0] stream;
      stream = {pbit, v};
`ifdef PARITY_CHECK_EN
      n = 9;
`else
      n = 8;
`endif
      for (int i = 0; i < n; i++) begin
         shift  = 1'b1;
         in_bit = stream[i];
         if (i == n - 1) out_ready = rl;
         tick();
      end
      shift  = 1'b0;
      in_bit = 1'b0;
   endtask

   // Send n raw data bits, all equal to b.
   task automatic send_bits(input int n, input logic b);
      for (int i = 0; i < n; i++) begin
         shift  = 1'b1;
         in_bit = b;
         tick();
      end
      shift  = 1'b0;
      in_bit = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; frame_rst = 1'b0; shift = 1'b0; in_bit = 1'b0;
      out_ready = 1'b0; ovr_clr = 1'b0;
      tick(); tick();
      rst = 1'b0;
      tick();

      // reset state
      chk("rst_valid", {15'd0, l_valid}, 16'd0);
      chk("rst_data",  {8'd0, l_data}, 16'd0);
      chk("rst_ovr",   {15'd0, l_ovr}, 16'd0);
      chk("rst_perr",  {15'd0, l_perr}, 16'd0);
      chk("rst_busy",  {15'd0, l_busy}, 16'd0);
      chk("rst_cnt",   {12'd0, l_cnt}, 16'd0);

      // 0xA5 stream 1,0,1,0,0,1,0,1 : palindrome in both orders
      out_ready = 1'b1;
      send_frame(8'hA5, 1'b0, 1'b1);
      chk("a5_lsb_data",  {8'd0, l_data}, 16'h00A5);
      chk("a5_msb_data",  {8'd0, m_data}, 16'h00A5);
      chk("a5_valid",     {15'd0, l_valid}, 16'd1);
      chk("a5_perr",      {15'd0, l_perr}, 16'd0);
      tick();
      chk("a5_valid_drop", {15'd0, l_valid}, 16'd0);
      chk("a5_data_hold",  {8'd0, l_data}, 16'h00A5);

      // stream 1,1,0,0,0,0,0,1 : 0x83 LSB-first, 0xC1 MSB-first
      send_frame(8'h83, 1'b1, 1'b1);
      chk("83_lsb_data", {8'd0, l_data}, 16'h0083);
      chk("c1_msb_data", {8'd0, m_data}, 16'h00C1);
      chk("83_msb_valid", {15'd0, m_valid}, 16'd1);
      tick();

      // overrun: 0x3C held, 0x5A lost; ovr_clr asserted during the losing
      // completion must not win over the set
      out_ready = 1'b0;
      send_frame(8'h3C, 1'b0, 1'b0);
      chk("3c_data", {8'd0, l_data}, 16'h003C);
      chk("3c_ovr",  {15'd0, l_ovr}, 16'd0);
      ovr_clr = 1'b1;
      send_frame(8'h5A, 1'b0, 1'b0);
      ovr_clr = 1'b0;
      chk("5a_kept_data", {8'd0, l_data}, 16'h003C);
      chk("5a_msb_data",  {8'd0, m_data}, 16'h003C);
      chk("5a_ovr_set",   {15'd0, l_ovr}, 16'd1);
      chk("5a_valid",     {15'd0, l_valid}, 16'd1);
      tick();
      chk("ovr_sticky",   {15'd0, l_ovr}, 16'd1);
      ovr_clr = 1'b1;
      tick();
      ovr_clr = 1'b0;
      chk("ovr_clr",      {15'd0, l_ovr}, 16'd0);
      chk("ovr_clr_data", {8'd0, l_data}, 16'h003C);
      out_ready = 1'b1;
      tick();
      chk("drain_valid", {15'd0, l_valid}, 16'd0);

      // partial word then frame_rst (with a same-cycle shift that is ignored)
      send_bits(4, 1'b1);
      chk("part_cnt",  {12'd0, l_cnt}, 16'd4);
      chk("part_busy", {15'd0, l_busy}, 16'd1);
      frame_rst = 1'b1; shift = 1'b1; in_bit = 1'b1;
      tick();
      frame_rst = 1'b0; shift = 1'b0; in_bit = 1'b0;
      chk("frst_cnt",  {12'd0, l_cnt}, 16'd0);
      chk("frst_busy", {15'd0, l_busy}, 16'd0);
      send_frame(8'h12, 1'b0, 1'b1);
      chk("12_lsb_data", {8'd0, l_data}, 16'h0012);
      chk("12_msb_data", {8'd0, m_data}, 16'h0048);
      chk("12_cnt",      {12'd0, l_cnt}, 16'd0);
      chk("12_busy",     {15'd0, l_busy}, 16'd0);
      tick();

      // back-to-back: second word accepted while first is drained same cycle
      out_ready = 1'b0;
      send_frame(8'h11, 1'b0, 1'b0);
      chk("11_data", {8'd0, l_data}, 16'h0011);
      send_frame(8'h22, 1'b0, 1'b1);
      chk("22_data",  {8'd0, l_data}, 16'h0022);
      chk("22_msb",   {8'd0, m_data}, 16'h0044);
      chk("22_valid", {15'd0, l_valid}, 16'd1);
      chk("22_ovr",   {15'd0, l_ovr}, 16'd0);
      tick();
      chk("22_drop", {15'd0, l_valid}, 16'd0);

`ifdef PARITY_CHECK_EN
      // parity: ^0x07 = 1; even sense
      send_frame(8'h07, 1'b1, 1'b1);
      chk("p07_good_data", {8'd0, l_data}, 16'h0007);
      chk("p07_good_perr", {15'd0, l_perr}, 16'd0);
      tick();
      send_frame(8'h07, 1'b0, 1'b1);
      chk("p07_bad_perr", {15'd0, l_perr}, 16'd1);
      chk("p07_bad_valid", {15'd0, l_valid}, 16'd1);
      tick();
`endif

      // mid-word reset after 5 bits, with a full holding stage and overrun
      out_ready = 1'b0;
      send_frame(8'h3C, 1'b0, 1'b0);
      send_frame(8'h5A, 1'b0, 1'b0);
      send_bits(5, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mrst_valid", {15'd0, l_valid}, 16'd0);
      chk("mrst_data",  {8'd0, l_data}, 16'd0);
      chk("mrst_ovr",   {15'd0, l_ovr}, 16'd0);
      chk("mrst_cnt",   {12'd0, l_cnt}, 16'd0);
      chk("mrst_busy",  {15'd0, l_busy}, 16'd0);
      out_ready = 1'b1;
      send_frame(8'hFF, 1'b0, 1'b1);
      chk("ff_data",  {8'd0, l_data}, 16'h00FF);
      chk("ff_valid", {15'd0, l_valid}, 16'd1);
      chk("ff_perr",  {15'd0, l_perr}, 16'd0);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
